// File: rtl/demux8_pkg.sv
// demux8_pkg: shared select-code definitions for the demux8 block.
//   sel_t      2-bit select code type
//   SEL_*      select code values (00 idle, 01 Q1, 10 Q2, 11 Q3)
//   NUM_PORTS  number of output ports
package demux8_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IDLE = 2'b00;
  localparam sel_t SEL_Q1   = 2'b01;
  localparam sel_t SEL_Q2   = 2'b10;
  localparam sel_t SEL_Q3   = 2'b11;

  localparam int NUM_PORTS = 3;

endpackage

// File: rtl/demux8_sel_decode.sv
// demux8_sel_decode: combinational select -> one-hot port enable.
//   s   in   sel_t           select code
//   en  out  [NUM_PORTS-1:0] one-hot enable, bit 0 = Q1 .. bit 2 = Q3
// Idle code and any unknown select produce 3'b000 (the exact-match case
// items never match X/Z bits, so such codes fall into the default).
module demux8_sel_decode
  import demux8_pkg::*;
(
  input  sel_t                 s,
  output logic [NUM_PORTS-1:0] en
);

  always_comb begin
    en = '0;
    case (s)
      SEL_IDLE: en = 3'b000;
      SEL_Q1:   en = 3'b001;
      SEL_Q2:   en = 3'b010;
      SEL_Q3:   en = 3'b100;
      default:  en = 3'b000;
    endcase
  end

endmodule

// File: rtl/demux8_3to1.sv
// demux8_3to1: registered 1-to-3 demultiplexer.
//   CLK    in   1      rising-edge clock
//   RST_N  in   1      asynchronous active-low reset, clears all outputs
//   I      in   WIDTH  data input
//   S      in   2      select: 00 idle, 01 -> Q1, 10 -> Q2, 11 -> Q3
//   Q1..Q3 out  WIDTH  registered output ports (one cycle latency)
// Build option DEMUX8_HOLD_EN: when defined, unselected ports keep their last
// value instead of clearing to zero; reset still clears everything.
module demux8_3to1
  import demux8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  sel_t             S,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3
);

  logic [NUM_PORTS-1:0]            en;
  logic [NUM_PORTS-1:0][WIDTH-1:0] q_r;

  demux8_sel_decode u_dec (
    .s  (S),
    .en (en)
  );

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        q_r[p] <= '0;
      end else begin
`ifdef DEMUX8_HOLD_EN
        if (en[p]) q_r[p] <= I;
`else
        q_r[p] <= en[p] ? I : '0;
`endif
      end
    end
  end

  assign Q1 = q_r[0];
  assign Q2 = q_r[1];
  assign Q3 = q_r[2];

endmodule

// File: tb/tb_demux8_3to1.sv
// tb_demux8_3to1: scoreboard bench for demux8_3to1. Stimulus drives I/S on the
// falling edge and queues the expected port values; a monitor samples 1 ns after
// each rising edge and pops/compares. Honors DEMUX8_HOLD_EN like the DUT.
module tb_demux8_3to1;

  typedef struct {
    logic [7:0] q1;
    logic [7:0] q2;
    logic [7:0] q3;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] I = '0;
  logic [1:0] S = '0;
  logic [7:0] Q1, Q2, Q3;

  exp_t       sb[$];
  logic [7:0] m[1:3];
  int         n_chk = 0;
  int         n_pass = 0;

  demux8_3to1 #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .I(I), .S(S), .Q1(Q1), .Q2(Q2), .Q3(Q3)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: the selected port (numbered by the code value) takes I; in
  // zero-clear mode every other port is zero, in hold mode it keeps its value.
  function automatic exp_t model_step(input logic [7:0] i, input logic [1:0] s);
    exp_t e;
`ifndef DEMUX8_HOLD_EN
    for (int k = 1; k <= 3; k++) m[k] = 8'h00;
`endif
    if (!$isunknown(s) && s != 2'd0) m[s] = i;
    e.q1 = m[1]; e.q2 = m[2]; e.q3 = m[3];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 1; k <= 3; k++) m[k] = 8'h00;
  endtask

  task automatic cycle(input logic [7:0] i, input logic [1:0] s);
    @(negedge CLK);
    I = i;
    S = s;
    sb.push_back(model_step(I, S));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q1"}, {24'd0, Q1}, 32'd0);
    chk({tag, "_q2"}, {24'd0, Q2}, 32'd0);
    chk({tag, "_q3"}, {24'd0, Q3}, 32'd0);
  endtask

  // Reset pulse placed between edges, after the monitor has sampled.
  task automatic pulse_reset(input string tag);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1 chk_zero(tag);
    model_reset();
    RST_N = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   nz;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_q1", {24'd0, Q1}, {24'd0, e.q1});
        chk("sb_q2", {24'd0, Q2}, {24'd0, e.q2});
        chk("sb_q3", {24'd0, Q3}, {24'd0, e.q3});
      end
`ifndef DEMUX8_HOLD_EN
      nz = int'(Q1 != 0) + int'(Q2 != 0) + int'(Q3 != 0);
      chk("at_most_one_nonzero", 32'(nz > 1), 32'd0);
`endif
    end
  end

  // Stimulus
  initial begin
    logic [1:0] sx;
    model_reset();
    I = 8'h05;
    S = 2'b01;
    #3 RST_N = 1'b0;
    #1 chk_zero("rst_async");
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1 chk_zero("rst_held");
    end
    // Release between edges; first capture on the following rising edge.
    @(negedge CLK);
    RST_N = 1'b1;
    sb.push_back(model_step(I, S));

    // Select sweep, data change on held select, hold-mode sequence.
    cycle(8'h05, 2'b00);
    cycle(8'h05, 2'b01);
    cycle(8'h05, 2'b10);
    cycle(8'h05, 2'b11);
    cycle(8'h0F, 2'b11);
    cycle(8'h11, 2'b01);
    cycle(8'h22, 2'b10);
    cycle(8'h33, 2'b00);
    cycle(8'h33, 2'b00);

    // Mid-stream reset clears Q2 at once, reloads after release.
    cycle(8'hA5, 2'b10);
    pulse_reset("rst_mid");
    cycle(8'hA5, 2'b10);
    cycle(8'hFF, 2'b01);

    // Unknown select is treated as idle.
    sx = 2'bx1;
    cycle(8'h05, sx);
    cycle(8'h00, 2'b00);

    // Random run.
    for (int n = 0; n < 1000; n++) begin
      cycle(8'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 199) == 0) pulse_reset("rst_rand");
    end

    repeat (3) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
